int_timer_ctrl: RTL
===================

# int_timer_ctrl

Parametrised interrupt-collection and countdown-timer unit owning the ECFG, ESTAT, TCFG, TVAL and TICLR control/status registers. It generalises the fixed 8-line hardware-interrupt / single-IPI inputs of the current core to a configurable line count, timer width and synchroniser depth. It sits beside the main CSR file, sharing its WB-stage read/write port, and drives `has_int` to the ID stage.

## Interface
Parameters:
- `HW_INT_NUM`, 8, hardware interrupt lines, 1..8; unused ESTAT.IS[9:2] bits read 0
- `TIMER_W`, 32, TVAL/TCFG counter width, 8..32
- `SYNC_STAGES`, 2, synchroniser flops per async input, ≥2

Ports:
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-high
- `hw_int_in` in HW_INT_NUM: asynchronous level-sensitive interrupt lines
- `ipi_int_in` in 1: asynchronous inter-processor interrupt, level
- `crmd_ie` in 1: global interrupt enable from CRMD
- `csr_re` in 1: read enable
- `csr_num` in 14: register number (ECFG 0x4, ESTAT 0x5, TCFG 0x41, TVAL 0x42, TICLR 0x44)
- `csr_rvalue` out 32: read data, combinational
- `csr_we` in 1: write enable
- `csr_wmask` in 32: bit write mask
- `csr_wvalue` in 32: write data
- `has_int` out 1: pending enabled interrupt

## Operation
- Reset: all registers 0; `csr_rvalue` 0, `has_int` 0, synchroniser flops 0.
- ECFG.LIE[12:0] writable through mask; bit 10 hard-wired 0.
- ESTAT.IS: [1:0] software, writable; [2+i] = synchronised `hw_int_in[i]`, read-only; [11] TI, timer sticky; [12] synchronised IPI; other bits 0.
- TCFG: [0] En, [1] Periodic, [TIMER_W-1:2] InitV.
- TCFG write: TVAL ← {InitV_new, 2'b00}.
- When En=1 and TVAL≠0: TVAL decrements by 1 per cycle.
- When En=1 and TVAL=0:
  - TI set.
  - Periodic=1: TVAL reloads {InitV,2'b00}.
  - Periodic=0: TVAL ← all ones, En cleared (single shot).
- TICLR: write with masked bit0=1 clears TI; reads 0.
- TVAL: read-only; writes ignored.
- `has_int` = `crmd_ie` & |(ESTAT.IS & ECFG.LIE), combinational.
- Reads:
  - `csr_rvalue` = selected register when `csr_re`, else 0.
  - Unmapped `csr_num` reads 0.
  - Bits above TIMER_W read 0.
- Simultaneous events:
  - Timer expiry and TICLR in the same cycle: TI set wins.
  - TCFG write and expiry in the same cycle: TI set still occurs, TVAL takes the written load value.
  - ESTAT write cannot change IS[12:2].

## Timing
- Read: zero latency; read-during-write returns the pre-write value.
- Write: takes effect at the next rising edge.
- Hardware line or IPI sampled high at edge k:
  - IS bit set after edge k+SYNC_STAGES.
  - `has_int` high in the same cycle, if enabled.
- Deassertion follows the same latency. HW and IPI bits are level, not sticky.
- Timer expiry: TCFG written with En=1, InitV=N at edge 0.
  - TVAL=4N after edge 0, reaching 0 after edge 4N.
  - TI set after edge 4N+1.
- Reset mid-count: timer stops immediately, TI and En cleared, all pending state lost.

## Configuration
- `INT_TIMER_EN` defined: timer logic, TCFG/TVAL/TICLR and IS[11] present as above.
- `INT_TIMER_EN` undefined:
  - No counter flops.
  - TCFG, TVAL and TICLR read 0; writes ignored.
  - IS[11] constant 0.
  - Interrupt collection unchanged.

## Structure
- Shared package:
  - CSR number constants: ECFG, ESTAT, TCFG, TVAL, TICLR.
  - IS/LIE bit positions: SWI, HWI base, TI, IPI.
  - TCFG field positions.
- Sub-module `int_sync`: parametrised SYNC_STAGES-deep flop chain, `reset` to 0. Instantiated once over the width HW_INT_NUM+1 to cover the HW lines and IPI.

## Test plan
- Reset asserted mid-count with TVAL=0x20 → all reads 0 next cycle, `has_int`=0.
- LIE=0x004, `crmd_ie`=1, `hw_int_in[0]` 0→1 at edge k → `has_int`=1 after edge k+SYNC_STAGES; with `crmd_ie`=0 it stays 0.
- TCFG ← 0x00000009 (En, one-shot, InitV=2) → TVAL reads 8,7…0; TI=1 one edge after TVAL=0; TVAL=0xFFFFFFFF; TCFG.En=0.
- TCFG ← 0x0000000B (periodic, InitV=2) → TI set every 9 cycles, TVAL reloads 8. TICLR ← 1 on an expiry cycle → TI stays 1.
- ESTAT write of 0xFFFFFFFF with mask all ones → IS reads 0x3 plus live HW/IPI/TI bits only. Read of `csr_num`=0x7 → 0.
- Built without `INT_TIMER_EN`: TCFG ← 0x9 → TCFG and TVAL read 0, IS[11] never sets.

Source files
------------

// File: rtl/int_timer_ctrl_pkg.sv
// Shared constants for the interrupt/timer CSR block: CSR numbers, IS/LIE bit map, TCFG fields.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package int_timer_ctrl_pkg;

    // CSR numbers served by this block
    localparam logic [13:0] CSR_ECFG  = 14'h0004;
    localparam logic [13:0] CSR_ESTAT = 14'h0005;
    localparam logic [13:0] CSR_TCFG  = 14'h0041;
    localparam logic [13:0] CSR_TVAL  = 14'h0042;
    localparam logic [13:0] CSR_TICLR = 14'h0044;

    // ESTAT.IS / ECFG.LIE bit positions
    localparam int IS_SWI_LSB  = 0;
    localparam int IS_SWI_W    = 2;
    localparam int IS_HWI_BASE = 2;
    localparam int IS_HWI_MAX  = 8;
    localparam int IS_TI       = 11;
    localparam int IS_IPI      = 12;
    localparam int LIE_W       = 13;

    // LIE bit 10 has no interrupt source behind it and is tied low
    localparam logic [LIE_W-1:0] LIE_WR_MASK = 13'h1BFF;

    // TCFG field positions
    localparam int TCFG_EN        = 0;
    localparam int TCFG_PERIODIC  = 1;
    localparam int TCFG_INITV_LSB = 2;

    // Bitwise masked merge used by every writable CSR field
    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wmask,
                                              input logic [31:0] wvalue);
        return (old_val & ~wmask) | (wvalue & wmask);
    endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-flop synchroniser for asynchronous level inputs, one chain per bit.
// Latency: input captured at edge k appears on d_out after edge k+STAGES-1.
// Backpressure: none; free-running level path.
module int_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    // Shift each stage forward by one; stage 0 captures the raw input
    always_comb begin
        sync_d = sync_q;
        sync_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Chain registers, cleared on reset so no stale level survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/int_timer_ctrl.sv
// Interrupt collection (ECFG/ESTAT) and countdown timer (TCFG/TVAL/TICLR); timer present only with INT_TIMER_EN.
// Latency: reads combinational; writes at next edge; async lines visible in IS SYNC_STAGES edges after capture.
// Backpressure: none; the CSR port accepts a read and a write every cycle.
module int_timer_ctrl
    import int_timer_ctrl_pkg::*;
#(
    parameter int HW_INT_NUM  = 8,
    parameter int TIMER_W     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [HW_INT_NUM-1:0] hw_int_in,
    input  logic                  ipi_int_in,
    input  logic                  crmd_ie,
    input  logic                  csr_re,
    input  logic [13:0]           csr_num,
    output logic [31:0]           csr_rvalue,
    input  logic                  csr_we,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wvalue,
    output logic                  has_int
);

    // ------------------------------------------------------------------
    // Async line synchronisation: HW lines in the low bits, IPI on top
    // ------------------------------------------------------------------
    logic [HW_INT_NUM:0] sync_out;

    int_sync #(
        .WIDTH  (HW_INT_NUM + 1),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d_in  ({ipi_int_in, hw_int_in}),
        .d_out (sync_out)
    );

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic wr_ecfg;
    logic wr_estat;

    assign wr_ecfg  = csr_we && (csr_num == CSR_ECFG);
    assign wr_estat = csr_we && (csr_num == CSR_ESTAT);

    // ------------------------------------------------------------------
    // ECFG.LIE and ESTAT.IS state
    // ------------------------------------------------------------------
    logic [LIE_W-1:0]      lie_q, lie_d;
    logic [IS_SWI_W-1:0]   swi_q, swi_d;
    logic [HW_INT_NUM-1:0] hwi_q, hwi_d;
    logic                  ipi_q, ipi_d;

    logic [31:0] ecfg_merged;
    logic [31:0] estat_merged;

    assign ecfg_merged  = csr_merge({{(32-LIE_W){1'b0}}, lie_q}, csr_wmask, csr_wvalue);
    assign estat_merged = csr_merge({{(32-IS_SWI_W){1'b0}}, swi_q}, csr_wmask, csr_wvalue);

    // Next state for LIE, software IS bits and the level-following HW/IPI bits
    always_comb begin
        lie_d = lie_q;
        swi_d = swi_q;
        hwi_d = sync_out[HW_INT_NUM-1:0];
        ipi_d = sync_out[HW_INT_NUM];
        if (wr_ecfg) begin
            lie_d = ecfg_merged[LIE_W-1:0] & LIE_WR_MASK;
        end
        // Only the software bits of ESTAT accept writes; IS[12:2] are hardware-owned
        if (wr_estat) begin
            swi_d = estat_merged[IS_SWI_W-1:0];
        end
    end

    // Interrupt state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lie_q <= '0;
            swi_q <= '0;
            hwi_q <= '0;
            ipi_q <= 1'b0;
        end else begin
            lie_q <= lie_d;
            swi_q <= swi_d;
            hwi_q <= hwi_d;
            ipi_q <= ipi_d;
        end
    end

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic        ti_bit;
    logic [31:0] tcfg_rd;
    logic [31:0] tval_rd;

`ifdef INT_TIMER_EN
    logic               wr_tcfg;
    logic               wr_ticlr;
    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               ti_q, ti_d;
    logic [TIMER_W-1:0] tcfg_wr;
    logic               tmr_expire;
    logic               ticlr_hit;

    assign wr_tcfg    = csr_we && (csr_num == CSR_TCFG);
    assign wr_ticlr   = csr_we && (csr_num == CSR_TICLR);
    assign tcfg_wr    = (tcfg_q & ~csr_wmask[TIMER_W-1:0]) | (csr_wvalue[TIMER_W-1:0] & csr_wmask[TIMER_W-1:0]);
    assign tmr_expire = tcfg_q[TCFG_EN] && (tval_q == '0);
    assign ticlr_hit  = wr_ticlr && csr_wmask[0] && csr_wvalue[0];

    // Countdown, expiry reload/stop, and TI set/clear; a TCFG write overrides the reload
    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        ti_d   = ti_q;
        if (tcfg_q[TCFG_EN] && (tval_q != '0)) begin
            tval_d = tval_q - 1'b1;
        end
        if (tmr_expire) begin
            if (tcfg_q[TCFG_PERIODIC]) begin
                tval_d = {tcfg_q[TIMER_W-1:TCFG_INITV_LSB], 2'b00};
            end else begin
                tval_d         = '1;
                tcfg_d[TCFG_EN] = 1'b0;
            end
        end
        if (wr_tcfg) begin
            tcfg_d = tcfg_wr;
            tval_d = {tcfg_wr[TIMER_W-1:TCFG_INITV_LSB], 2'b00};
        end
        // Expiry is applied after the clear so a coincident TICLR cannot lose it
        if (ticlr_hit) begin
            ti_d = 1'b0;
        end
        if (tmr_expire) begin
            ti_d = 1'b1;
        end
    end

    // Timer registers; reset stops the count and drops any pending TI
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcfg_q <= '0;
            tval_q <= '0;
            ti_q   <= 1'b0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            ti_q   <= ti_d;
        end
    end

    assign ti_bit  = ti_q;
    assign tcfg_rd = 32'(tcfg_q);
    assign tval_rd = 32'(tval_q);
`else
    assign ti_bit  = 1'b0;
    assign tcfg_rd = '0;
    assign tval_rd = '0;
`endif

    // Write-data bits that no field consumes in narrower configurations
    logic unused_wr_bits;
    assign unused_wr_bits = ^{csr_wmask, csr_wvalue};

    // ------------------------------------------------------------------
    // ESTAT image, interrupt request and read mux
    // ------------------------------------------------------------------
    logic [31:0] estat_rd;

    // Assemble IS; HW lines beyond HW_INT_NUM and bit 10 stay zero
    always_comb begin
        estat_rd = '0;
        estat_rd[IS_SWI_LSB +: IS_SWI_W]    = swi_q;
        estat_rd[IS_HWI_BASE +: HW_INT_NUM] = hwi_q;
        estat_rd[IS_TI]                     = ti_bit;
        estat_rd[IS_IPI]                    = ipi_q;
    end

    assign has_int = crmd_ie && (|(estat_rd[LIE_W-1:0] & lie_q));

    // Zero-latency read; TICLR and unmapped numbers read as zero
    always_comb begin
        csr_rvalue = '0;
        if (csr_re) begin
            case (csr_num)
                CSR_ECFG:  csr_rvalue = {{(32-LIE_W){1'b0}}, lie_q};
                CSR_ESTAT: csr_rvalue = estat_rd;
                CSR_TCFG:  csr_rvalue = tcfg_rd;
                CSR_TVAL:  csr_rvalue = tval_rd;
                default:   csr_rvalue = '0;
            endcase
        end
    end

endmodule
